m_stage: RTL and testbench
==========================

Name: m_stage

Overview:
- Memory (M) pipeline stage of the exception-capable five-stage MIPS core. It sits directly downstream of the E stage and upstream of W.
- Latches E's outputs in the E/M pipeline register and generates data-bus transfers for loads and stores over a req/ack handshake.
- Aligns store data and extends load data.
- Detects address exceptions, and stalls the pipeline while a transfer is outstanding, with a timeout watchdog.

Parameters:
- TIMEOUT, 15, cycles waiting for m_ack before the access is abandoned with DBE.
- DM_TOP, 32'h0000_2FFF, highest valid data-memory byte address.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- IntReq  in  1  CP0 flush; clears the stage register and kills any pending access
- MBFMUXSrc  in  3  RD2 forwarding select: 0 = latched RD2, nonzero = W_FRegData
- W_FRegData  in  32  W-stage forwarded value
- E_Instr, E_PC, E_RegData, E_RD2  in  32 each  E-stage outputs
- E_RegAddr  in  5
- E_RegWrite  in  1
- E_CP0Write  in  1
- E_Tnew  in  3
- E_ExcCode  in  5
- E_BD  in  1
- m_req  out  1  bus request
- m_wr  out  1  1 = store
- m_addr  out  32
- m_byteen  out  4
- m_wdata  out  32
- m_ack  in  1  a transfer completes in any cycle where m_req && m_ack
- m_rdata  in  32  valid while m_ack is high
- M_Instr, M_PC  out  32 each
- M_RegData  out  32  writeback value (load data or latched E_RegData)
- M_FRegData  out  32  forward-only value (latched E_RegData)
- M_RD2  out  32  forwarded store data
- M_RegAddr  out  5
- M_RegWrite  out  1
- M_CP0Write  out  1
- M_Tnew  out  3
- M_ExcCode  out  5
- M_BD  out  1
- M_BadVAddr  out  32
- M_Busy  out  1  stall request to F/D/E

Behaviour:
- Reset (reset=0, asynchronous): all stage-register fields = 0, state = IDLE, timeout counter = 0. Every output is therefore 0, including m_req and M_Busy.
- Stage register:
  - Loads from E on each clock edge when !M_Busy && !IntReq.
  - IntReq=1 clears it synchronously to a bubble, and overrides M_Busy.
  - When M_Busy=1 it holds, except RD2, which reloads with the forwarded value every cycle. This preserves a W value that leaves W while M stalls.
- M_Tnew = (E_Tnew > 0) ? E_Tnew - 1 : 0, latched.
- Address: addr = latched E_RegData (ALU result).
- Memory-op decode (opcode):
  - Loads: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24.
  - Stores: sw 0x2B, sh 0x29, sb 0x28.
- Exception detection, priority order:
  1. Incoming E_ExcCode == Ov(12) on a memory op is rewritten to AdEL(4) for a load or AdES(5) for a store.
  2. Any other nonzero E_ExcCode passes through unchanged.
  3. Misaligned access (lw/sw: addr[1:0] != 0; lh/lhu/sh: addr[0] != 0) raises AdEL (load) or AdES (store).
  4. Out-of-range address raises AdEL/AdES. Valid ranges are [0, DM_TOP], 0x7F00–0x7F0B, 0x7F10–0x7F1B and 0x7F20–0x7F23.
  5. A half/byte access to 0x7F00–0x7F23 raises AdEL/AdES.
  6. A store to 0x7F08 or 0x7F18 (timer count registers) raises AdES.
- M_BadVAddr = addr when AdEL/AdES is raised, else 0.
- m_req = memop && exc==0 && !IntReq && state != ABORT.
- m_addr = {addr[31:2], 2'b00}.
- Store byteen / wdata:
  - sw: byteen 1111.
  - sh: byteen addr[1] ? 1100 : 0011, wdata = {2{RD2[15:0]}}.
  - sb: byteen = 1 << addr[1:0], wdata = {4{RD2[7:0]}}.
- Load data, taken combinationally from m_rdata in the ack cycle:
  - lh/lhu select the half by addr[1]; lb/lbu select the byte by addr[1:0].
  - lh/lb sign-extend; lhu/lbu zero-extend.
- M_RegData = load ? extended data : latched E_RegData.
- FSM:
  - IDLE:
    - m_req && m_ack: transfer done, M_Busy = 0, stay IDLE.
    - m_req && !m_ack: go to WAIT, counter = 1, M_Busy = 1.
  - WAIT:
    - m_ack: M_Busy = 0 this cycle, go to IDLE.
    - otherwise counter++; when counter == TIMEOUT, go to ABORT.
    - IntReq: go to IDLE, counter = 0; no transfer occurs.
  - ABORT (one cycle):
    - m_req = 0, M_Busy = 0, M_ExcCode = DBE(7), M_RegWrite forced to 0.
    - Go to IDLE as the instruction advances.
- Zero-wait ack gives 0 stall cycles. An ack n cycles late gives n stall cycles.

Decomposition:
- Shared header macro.v holds:
  - opcode constants.
  - ExcCode constants AdEL=4, AdES=5, DBE=7, Ov=12.
  - address-map bounds.
  - M-stage state encodings.
- One sub-module, m_data_align (combinational): computes byteen and wdata from opcode/addr/RD2, and the load extension from opcode/addr/rdata.

Test Plan:
- sw, addr 0x1004, RD2 0x12345678, ack same cycle -> m_req=1, m_wr=1, m_byteen=1111, m_wdata=0x12345678, M_Busy=0.
- lb, addr 0x1003, ack 3 cycles late, rdata 0x8A000000 -> M_Busy high 3 cycles, M_RegData=0xFFFFFF8A in the ack cycle; lbu gives 0x0000008A.
- lw at 0x1002 -> M_ExcCode=4, M_BadVAddr=0x1002, m_req never asserted. sh at 0x7F08 -> M_ExcCode=5. sw at 0x7F08 -> 5.
- lw at 0x0, m_ack held low -> M_Busy high 15 cycles, then M_ExcCode=7, M_RegWrite=0, pipeline advances.
- sw waiting, IntReq pulsed in 2nd WAIT cycle -> m_req=0 that cycle, no req&&ack cycle, stage outputs 0 next cycle. reset=0 mid-WAIT -> all outputs 0 immediately.
- sw, MBFMUXSrc=1, W_FRegData=0xDEADBEEF in first cycle, then MBFMUXSrc=0, W_FRegData=0, ack 2 cycles later -> m_wdata=0xDEADBEEF at ack.

Source files
------------

// File: rtl/m_stage_pkg.sv
// Shared constants and types for the M pipeline stage.
// Contents: load/store opcodes, exception codes, the I/O address map,
// the M-stage FSM encoding and the E/M stage-register layout.
package m_stage_pkg;

  // Memory opcodes (instr[31:26])
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;

  // Exception codes
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Peripheral window: timer0, timer1, interrupt generator
  localparam logic [31:0] IO_T0_LO   = 32'h0000_7F00;
  localparam logic [31:0] IO_T0_HI   = 32'h0000_7F0B;
  localparam logic [31:0] IO_T1_LO   = 32'h0000_7F10;
  localparam logic [31:0] IO_T1_HI   = 32'h0000_7F1B;
  localparam logic [31:0] IO_INT_LO  = 32'h0000_7F20;
  localparam logic [31:0] IO_INT_HI  = 32'h0000_7F23;
  // Timer count registers are read-only
  localparam logic [31:0] TIMER_CNT0 = 32'h0000_7F08;
  localparam logic [31:0] TIMER_CNT1 = 32'h0000_7F18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } m_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] regdata;
    logic [31:0] rd2;
    logic [4:0]  regaddr;
    logic        regwrite;
    logic        cp0write;
    logic [2:0]  tnew;
    logic [4:0]  exccode;
    logic        bd;
  } m_reg_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/m_data_align.sv
// Store byte-lane alignment and load extension for the M stage.
// Latency: purely combinational. Backpressure: none.
// Ports: op_i/addr_lo_i/rd2_i -> byteen_o/wdata_o (stores); rdata_i -> ld_data_o (loads).
module m_data_align
  import m_stage_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rd2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  byteen_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase

    // Narrow stores replicate the datum across lanes; byteen picks the lane.
    byteen_o = 4'b0000;
    wdata_o  = 32'h0;
    case (op_i)
      OP_SW: begin
        byteen_o = 4'b1111;
        wdata_o  = rd2_i;
      end
      OP_SH: begin
        byteen_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o  = {2{rd2_i[15:0]}};
      end
      OP_SB: begin
        byteen_o = 4'b0001 << addr_lo_i;
        wdata_o  = {4{rd2_i[7:0]}};
      end
      default: ;
    endcase

    ld_data_o = rdata_i;
    case (op_i)
      OP_LH:   ld_data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ld_data_o = {16'h0, half_sel};
      OP_LB:   ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ld_data_o = {24'h0, byte_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/m_stage.sv
// M pipeline stage: E/M register, data-bus req/ack transfers, address exceptions.
// Latency: 1 cycle E->M; a load/store holds M (M_Busy) until m_ack, or TIMEOUT cycles then DBE.
// Backpressure: M_Busy stalls F/D/E; IntReq flushes the stage and kills any pending access.
module m_stage
  import m_stage_pkg::*;
#(
  parameter int          TIMEOUT = 15,
  parameter logic [31:0] DM_TOP  = 32'h0000_2FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IntReq,
  input  logic [2:0]  MBFMUXSrc,
  input  logic [31:0] W_FRegData,
  input  logic [31:0] E_Instr,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_RegData,
  input  logic [31:0] E_RD2,
  input  logic [4:0]  E_RegAddr,
  input  logic        E_RegWrite,
  input  logic        E_CP0Write,
  input  logic [2:0]  E_Tnew,
  input  logic [4:0]  E_ExcCode,
  input  logic        E_BD,
  output logic        m_req,
  output logic        m_wr,
  output logic [31:0] m_addr,
  output logic [3:0]  m_byteen,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic [31:0] M_Instr,
  output logic [31:0] M_PC,
  output logic [31:0] M_RegData,
  output logic [31:0] M_FRegData,
  output logic [31:0] M_RD2,
  output logic [4:0]  M_RegAddr,
  output logic        M_RegWrite,
  output logic        M_CP0Write,
  output logic [2:0]  M_Tnew,
  output logic [4:0]  M_ExcCode,
  output logic        M_BD,
  output logic [31:0] M_BadVAddr,
  output logic        M_Busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  m_reg_t         stg_q, stg_d;
  m_state_e       state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;

  logic [5:0]  op;
  logic [31:0] addr, fwd_rd2, ld_data, al_wdata;
  logic [3:0]  al_byteen;
  logic        ld, st, memop, is_word, is_half;
  logic        misalign, in_io, in_map, io_narrow, timer_st;
  logic [4:0]  adr_code, exc;
  logic        exc_raised;

  assign op      = stg_q.instr[31:26];
  assign addr    = stg_q.regdata;
  assign ld      = is_load(op);
  assign st      = is_store(op);
  assign memop   = ld | st;
  assign is_word = (op == OP_LW) || (op == OP_SW);
  assign is_half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);

  assign misalign  = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
  assign in_io     = (addr >= IO_T0_LO) && (addr <= IO_INT_HI);
  assign in_map    = (addr <= DM_TOP) ||
                     ((addr >= IO_T0_LO)  && (addr <= IO_T0_HI)) ||
                     ((addr >= IO_T1_LO)  && (addr <= IO_T1_HI)) ||
                     ((addr >= IO_INT_LO) && (addr <= IO_INT_HI));
  assign io_narrow = in_io && !is_word;
  assign timer_st  = st && ((addr == TIMER_CNT0) || (addr == TIMER_CNT1));
  assign adr_code  = ld ? EXC_ADEL : EXC_ADES;

  // Earlier exceptions win; an ALU overflow on an address becomes an address error.
  always_comb begin
    exc        = EXC_NONE;
    exc_raised = 1'b0;
    if (memop && (stg_q.exccode == EXC_OV)) begin
      exc        = adr_code;
      exc_raised = 1'b1;
    end else if (stg_q.exccode != EXC_NONE) begin
      exc = stg_q.exccode;
    end else if (memop && (misalign || !in_map || io_narrow || timer_st)) begin
      exc        = adr_code;
      exc_raised = 1'b1;
    end
  end

  assign fwd_rd2 = (MBFMUXSrc != 3'd0) ? W_FRegData : stg_q.rd2;

  assign m_req  = memop && (exc == EXC_NONE) && !IntReq && (state_q != ST_ABORT);
  assign M_Busy = m_req && !m_ack;

  m_data_align u_align (
    .op_i      (op),
    .addr_lo_i (addr[1:0]),
    .rd2_i     (fwd_rd2),
    .rdata_i   (m_rdata),
    .byteen_o  (al_byteen),
    .wdata_o   (al_wdata),
    .ld_data_o (ld_data)
  );

  assign m_wr     = m_req && st;
  assign m_addr   = {addr[31:2], 2'b00};
  assign m_byteen = m_req ? al_byteen : 4'b0000;
  assign m_wdata  = al_wdata;

  assign M_Instr    = stg_q.instr;
  assign M_PC       = stg_q.pc;
  assign M_RegData  = ld ? ld_data : stg_q.regdata;
  assign M_FRegData = stg_q.regdata;
  assign M_RD2      = fwd_rd2;
  assign M_RegAddr  = stg_q.regaddr;
  assign M_RegWrite = stg_q.regwrite && (state_q != ST_ABORT);
  assign M_CP0Write = stg_q.cp0write;
  assign M_Tnew     = stg_q.tnew;
  assign M_ExcCode  = (state_q == ST_ABORT) ? EXC_DBE : exc;
  assign M_BD       = stg_q.bd;
  assign M_BadVAddr = exc_raised ? addr : 32'h0;

  // While stalled, RD2 keeps re-capturing the forwarded value so a W result
  // that retires during the stall is not lost.
  always_comb begin
    stg_d = stg_q;
    if (IntReq) begin
      stg_d = '0;
    end else if (M_Busy) begin
      stg_d.rd2 = fwd_rd2;
    end else begin
      stg_d.instr    = E_Instr;
      stg_d.pc       = E_PC;
      stg_d.regdata  = E_RegData;
      stg_d.rd2      = E_RD2;
      stg_d.regaddr  = E_RegAddr;
      stg_d.regwrite = E_RegWrite;
      stg_d.cp0write = E_CP0Write;
      stg_d.tnew     = (E_Tnew != 3'd0) ? (E_Tnew - 3'd1) : 3'd0;
      stg_d.exccode  = E_ExcCode;
      stg_d.bd       = E_BD;
    end
  end

  // cnt_q counts stalled cycles; reaching TIMEOUT abandons the access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CW'(1);
    case (state_q)
      ST_IDLE: begin
        if (m_req && !m_ack) begin
          state_d = ST_WAIT;
          cnt_d   = CW'(1);
        end
      end
      ST_WAIT: begin
        if (IntReq || m_ack) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          state_d = ST_ABORT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_q   <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      stg_q   <= stg_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_m_stage.sv
// Bench for m_stage: instruction-level reference model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_m_stage;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        IntReq;
  logic [2:0]  MBFMUXSrc;
  logic [31:0] W_FRegData;
  logic [31:0] E_Instr, E_PC, E_RegData, E_RD2;
  logic [4:0]  E_RegAddr;
  logic        E_RegWrite, E_CP0Write;
  logic [2:0]  E_Tnew;
  logic [4:0]  E_ExcCode;
  logic        E_BD;
  logic        m_req, m_wr;
  logic [31:0] m_addr;
  logic [3:0]  m_byteen;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic [31:0] M_Instr, M_PC, M_RegData, M_FRegData, M_RD2;
  logic [4:0]  M_RegAddr;
  logic        M_RegWrite, M_CP0Write;
  logic [2:0]  M_Tnew;
  logic [4:0]  M_ExcCode;
  logic        M_BD;
  logic [31:0] M_BadVAddr;
  logic        M_Busy;

  always #5 clk = ~clk;

  m_stage dut (
    .clk(clk), .reset(reset), .IntReq(IntReq), .MBFMUXSrc(MBFMUXSrc), .W_FRegData(W_FRegData),
    .E_Instr(E_Instr), .E_PC(E_PC), .E_RegData(E_RegData), .E_RD2(E_RD2),
    .E_RegAddr(E_RegAddr), .E_RegWrite(E_RegWrite), .E_CP0Write(E_CP0Write),
    .E_Tnew(E_Tnew), .E_ExcCode(E_ExcCode), .E_BD(E_BD),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_byteen(m_byteen), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .M_Instr(M_Instr), .M_PC(M_PC), .M_RegData(M_RegData), .M_FRegData(M_FRegData),
    .M_RD2(M_RD2), .M_RegAddr(M_RegAddr), .M_RegWrite(M_RegWrite), .M_CP0Write(M_CP0Write),
    .M_Tnew(M_Tnew), .M_ExcCode(M_ExcCode), .M_BD(M_BD), .M_BadVAddr(M_BadVAddr),
    .M_Busy(M_Busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The instruction sitting in M, how long it has been stalled, and whether
  // its access has been abandoned.
  typedef struct packed {
    logic [31:0] instr, pc, regdata, rd2;
    logic [4:0]  regaddr;
    logic        rw, cp0;
    logic [2:0]  tnew;
    logic [4:0]  ein;
    logic        bd;
    logic [7:0]  waited;
    logic        abort;
  } mdl_t;

  mdl_t mdl;

  function automatic bit op_ld(input logic [5:0] op);
    return op inside {6'h23, 6'h21, 6'h25, 6'h20, 6'h24};
  endfunction
  function automatic bit op_st(input logic [5:0] op);
    return op inside {6'h2B, 6'h29, 6'h28};
  endfunction
  function automatic int op_size(input logic [5:0] op);
    if (op inside {6'h23, 6'h2B}) return 4;
    if (op inside {6'h21, 6'h25, 6'h29}) return 2;
    return 1;
  endfunction

  // {raised_here, code}
  function automatic logic [5:0] classify(input logic [5:0] op, input logic [31:0] a,
                                          input logic [4:0] ein);
    bit ld, st, ok_map, io;
    logic [4:0] ac;
    int sz;
    ld = op_ld(op);
    st = op_st(op);
    sz = op_size(op);
    ac = ld ? 5'd4 : 5'd5;
    if (!(ld || st)) return {1'b0, ein};
    if (ein == 5'd12) return {1'b1, ac};
    if (ein != 5'd0) return {1'b0, ein};
    ok_map = (a <= 32'h2FFF) || (a >= 32'h7F00 && a <= 32'h7F0B) ||
             (a >= 32'h7F10 && a <= 32'h7F1B) || (a >= 32'h7F20 && a <= 32'h7F23);
    io = (a >= 32'h7F00 && a <= 32'h7F23);
    if ((a & 32'(sz - 1)) != 0) return {1'b1, ac};
    if (!ok_map) return {1'b1, ac};
    if (io && sz != 4) return {1'b1, ac};
    if (st && (a == 32'h7F08 || a == 32'h7F18)) return {1'b1, ac};
    return 6'd0;
  endfunction

  function automatic logic [31:0] load_val(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] b, h;
    b = rd >> (8 * a[1:0]);
    h = rd >> (16 * a[1]);
    case (op)
      6'h20: return 32'($signed(b[7:0]));
      6'h24: return {24'h0, b[7:0]};
      6'h21: return 32'($signed(h[15:0]));
      6'h25: return {16'h0, h[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] fwd_of(input mdl_t m);
    return (MBFMUXSrc != 3'd0) ? W_FRegData : m.rd2;
  endfunction

  function automatic bit req_of(input mdl_t m);
    logic [5:0] op, cl;
    op = m.instr[31:26];
    cl = classify(op, m.regdata, m.ein);
    return (op_ld(op) || op_st(op)) && cl[4:0] == 5'd0 && !IntReq && !m.abort;
  endfunction

  function automatic mdl_t stall_next(input mdl_t m);
    mdl_t n;
    n = m;
    n.rd2 = fwd_of(m);
    n.waited = m.waited + 8'd1;
    if (n.waited == 8'(TIMEOUT)) begin
      n.abort = 1'b1;
      n.waited = 8'd0;
    end
    return n;
  endfunction

  function automatic mdl_t load_from_e();
    mdl_t n;
    n = '0;
    n.instr = E_Instr; n.pc = E_PC; n.regdata = E_RegData; n.rd2 = E_RD2;
    n.regaddr = E_RegAddr; n.rw = E_RegWrite; n.cp0 = E_CP0Write;
    n.tnew = (E_Tnew > 0) ? E_Tnew - 3'd1 : 3'd0;
    n.ein = E_ExcCode; n.bd = E_BD;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset)                            mdl <= '0;
    else if (IntReq)                       mdl <= '0;
    else if (req_of(mdl) && !m_ack)        mdl <= stall_next(mdl);
    else                                   mdl <= load_from_e();
  end

  task automatic compare_cycle();
    mdl_t c;
    logic [5:0] op, cl;
    logic [31:0] a, fwd, wd;
    logic [3:0] be;
    bit ld, st, req;
    c   = reset ? mdl : '0;
    op  = c.instr[31:26];
    a   = c.regdata;
    ld  = op_ld(op);
    st  = op_st(op);
    cl  = classify(op, a, c.ein);
    fwd = fwd_of(c);
    req = req_of(c);
    be  = 4'h0;
    wd  = 32'h0;
    if (st) begin
      case (op)
        6'h2B: begin be = 4'hF; wd = fwd; end
        6'h29: begin be = a[1] ? 4'hC : 4'h3; wd = fwd[15:0] * 32'h0001_0001; end
        default: begin be = 4'(1 << a[1:0]); wd = fwd[7:0] * 32'h0101_0101; end
      endcase
    end
    if (!req) be = 4'h0;
    chk("m_req",      m_req,      req);
    chk("m_wr",       m_wr,       req && st);
    chk("m_addr",     m_addr,     a & ~32'h3);
    chk("m_byteen",   m_byteen,   be);
    chk("m_wdata",    m_wdata,    wd);
    chk("M_Busy",     M_Busy,     req && !m_ack);
    chk("M_Instr",    M_Instr,    c.instr);
    chk("M_PC",       M_PC,       c.pc);
    chk("M_RegData",  M_RegData,  ld ? load_val(op, a, m_rdata) : a);
    chk("M_FRegData", M_FRegData, a);
    chk("M_RD2",      M_RD2,      fwd);
    chk("M_RegAddr",  M_RegAddr,  c.regaddr);
    chk("M_RegWrite", M_RegWrite, c.rw && !c.abort);
    chk("M_CP0Write", M_CP0Write, c.cp0);
    chk("M_Tnew",     M_Tnew,     c.tnew);
    chk("M_ExcCode",  M_ExcCode,  c.abort ? 5'd7 : cl[4:0]);
    chk("M_BD",       M_BD,       c.bd);
    chk("M_BadVAddr", M_BadVAddr, cl[5] ? a : 32'h0);
  endtask

  always @(negedge clk) compare_cycle();

  // ---------------- directed stimulus ----------------
  logic [31:0] pc_ctr = 32'h0000_3000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    E_Instr = 0; E_PC = 0; E_RegData = 0; E_RD2 = 0; E_RegAddr = 0;
    E_RegWrite = 0; E_CP0Write = 0; E_Tnew = 0; E_ExcCode = 0; E_BD = 0;
  endtask

  // Called just after a rising edge; the instruction is in M after the next one.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd2,
                       input logic [4:0] ein);
    E_Instr = {op, 26'h0_4A_0000}; E_PC = pc_ctr; E_RegData = a; E_RD2 = rd2;
    E_RegAddr = 5'd9; E_RegWrite = 1'b1; E_CP0Write = 1'b0; E_Tnew = 3'd3;
    E_ExcCode = ein; E_BD = 1'b0;
    pc_ctr = pc_ctr + 4;
    step();
    bubble();
  endtask

  initial begin
    int cnt;
    reset = 0; IntReq = 0; MBFMUXSrc = 0; W_FRegData = 0; m_ack = 0; m_rdata = 0;
    bubble();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_req", m_req, 0);
    chk("rst_busy", M_Busy, 0);
    chk("rst_regdata", M_RegData, 0);
    step();
    reset = 1;

    // sw, ack in the same cycle
    m_ack = 1;
    issue(6'h2B, 32'h1004, 32'h1234_5678, 0);
    @(negedge clk);
    chk("sw_req", m_req, 1);
    chk("sw_wr", m_wr, 1);
    chk("sw_byteen", m_byteen, 4'hF);
    chk("sw_wdata", m_wdata, 32'h1234_5678);
    chk("sw_busy", M_Busy, 0);
    chk("sw_tnew", M_Tnew, 3'd2);
    step();

    // sh / sb lanes, lh / lhu extension, all zero-wait
    issue(6'h29, 32'h1006, 32'hAAAA_BBCC, 0);
    @(negedge clk);
    chk("sh_byteen", m_byteen, 4'hC);
    chk("sh_wdata", m_wdata, 32'hBBCC_BBCC);
    step();
    issue(6'h28, 32'h1001, 32'h0000_00EF, 0);
    @(negedge clk);
    chk("sb_byteen", m_byteen, 4'h2);
    chk("sb_wdata", m_wdata, 32'hEFEF_EFEF);
    step();
    m_rdata = 32'h8001_7FFF;
    issue(6'h21, 32'h1002, 0, 0);
    @(negedge clk);
    chk("lh_data", M_RegData, 32'hFFFF_8001);
    step();
    issue(6'h25, 32'h1000, 0, 0);
    @(negedge clk);
    chk("lhu_data", M_RegData, 32'h0000_7FFF);
    step();
    m_ack = 0; m_rdata = 0;

    // lb / lbu with ack three cycles late
    for (int v = 0; v < 2; v++) begin
      issue(v == 0 ? 6'h20 : 6'h24, 32'h1003, 0, 0);
      cnt = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (M_Busy) cnt++;
        step();
      end
      m_ack = 1; m_rdata = 32'h8A00_0000;
      @(negedge clk);
      chk("lb_stall", cnt, 3);
      chk("lb_busy_ack", M_Busy, 0);
      chk("lb_data", M_RegData, v == 0 ? 32'hFFFF_FF8A : 32'h0000_008A);
      step();
      m_ack = 0; m_rdata = 0;
    end

    // address exceptions
    issue(6'h23, 32'h1002, 0, 0);
    @(negedge clk);
    chk("lw_mis_exc", M_ExcCode, 4);
    chk("lw_mis_bva", M_BadVAddr, 32'h1002);
    chk("lw_mis_req", m_req, 0);
    step();
    issue(6'h29, 32'h7F08, 0, 0);
    @(negedge clk);
    chk("sh_io_exc", M_ExcCode, 5);
    step();
    issue(6'h2B, 32'h7F08, 0, 0);
    @(negedge clk);
    chk("sw_tmr_exc", M_ExcCode, 5);
    step();
    issue(6'h23, 32'h3000, 0, 0);
    @(negedge clk);
    chk("lw_oor_exc", M_ExcCode, 4);
    step();
    issue(6'h23, 32'h1000, 0, 5'd12);
    @(negedge clk);
    chk("lw_ov_exc", M_ExcCode, 4);
    step();
    issue(6'h00, 32'h1000, 0, 5'd12);
    @(negedge clk);
    chk("alu_ov_exc", M_ExcCode, 12);
    step();

    // timeout: lw at 0 never acked
    issue(6'h23, 32'h0, 0, 0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!M_Busy) break;
      cnt++;
      step();
    end
    chk("to_stall", cnt, 15);
    chk("to_exc", M_ExcCode, 7);
    chk("to_regwrite", M_RegWrite, 0);
    chk("to_req", m_req, 0);
    step();
    @(negedge clk);
    chk("to_after_exc", M_ExcCode, 0);
    step();

    // IntReq in the second WAIT cycle
    issue(6'h2B, 32'h1008, 32'h55, 0);
    step();
    step();
    IntReq = 1; m_ack = 1;
    #1;
    chk("irq_req", m_req, 0);
    chk("irq_no_xfer", m_req && m_ack, 0);
    step();
    IntReq = 0; m_ack = 0;
    @(negedge clk);
    chk("irq_instr", M_Instr, 0);
    chk("irq_pc", M_PC, 0);
    step();

    // asynchronous reset mid-WAIT
    issue(6'h2B, 32'h100C, 32'h66, 0);
    step();
    #1 reset = 0;
    #1;
    chk("arst_req", m_req, 0);
    chk("arst_busy", M_Busy, 0);
    chk("arst_instr", M_Instr, 0);
    step();
    reset = 1;

    // forwarded store data survives the W value leaving
    issue(6'h2B, 32'h1010, 32'h0, 0);
    MBFMUXSrc = 1; W_FRegData = 32'hDEAD_BEEF;
    step();
    MBFMUXSrc = 0; W_FRegData = 0;
    step();
    m_ack = 1;
    @(negedge clk);
    chk("fwd_req", m_req, 1);
    chk("fwd_wdata", m_wdata, 32'hDEAD_BEEF);
    step();
    m_ack = 0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
